serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Optional signed-overflow output `ovf` is built when SERIAL_ADD_OVF_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_c;
    logic load;

    // Full-adder cell fed by the operand LSBs and the carry flop.
    assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    // A request is only honoured when no operation is in flight.
    assign load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this last bit.
                    ovf_d   = carry_q ^ fa_c;
`endif
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            sum_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_d   = 1'b0;
`endif
            state_d = S_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): scoreboard of expected results popped at each done pulse.
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int               busy_cnt;
    int               done_idx;
    logic [WIDTH-1:0] obs_sum;
    logic             obs_cout;
    logic             obs_ovf;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        exp_t e;
        logic [WIDTH:0] t;
        t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Drive a start request now; it is accepted at the next rising edge.
    task start_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        a_i   = x;
        b_i   = y;
        cin_i = c;
        start = 1'b1;
        sb.push_back(model(x, y, c));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts busy cycles until done; optionally pulses a stray start with a=0xAA during SHIFT.
    task wait_done(input string tag, input int inject_at);
        busy_cnt = 0;
        done_idx = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_idx = i;
                obs_sum  = sum;
                obs_cout = cout;
`ifdef SERIAL_ADD_OVF_EN
                obs_ovf  = ovf;
`else
                obs_ovf  = 1'b0;
`endif
                break;
            end
            if (inject_at > 0 && i == inject_at) begin
                start = 1'b1;
                a_i   = 8'hAA;
            end
            if (inject_at > 0 && i == inject_at + 2) start = 1'b0;
        end
        if (done_idx == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done never seen, got none, required done within 40 cycles", tag);
        end
    endtask

    task test_reset;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef SERIAL_ADD_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
    endtask

    task test_basic;
        exp_t e;
        start_add(8'h0F, 8'h01, 1'b0);
        wait_done("basic", 0);
        e = sb.pop_front();
        $display("basic: 0F+01+0 -> sum=%h cout=%b busy_cycles=%0d done_at=%0d", obs_sum, obs_cout, busy_cnt, done_idx);
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL basic_busy_len got=%0d exp=8", busy_cnt); end
        checks++; if (done_idx !== 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", done_idx); end
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL basic_sum got=%h exp=%h", obs_sum, e.sum); end
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL basic_cout got=%b exp=%b", obs_cout, e.cout); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
        checks++; if (sum !== e.sum) begin errors++; $display("FAIL basic_sum_hold got=%h exp=%h", sum, e.sum); end
    endtask

    task test_carry;
        exp_t e;
        start_add(8'hFF, 8'h01, 1'b0);
        wait_done("carry1", 0);
        e = sb.pop_front();
        $display("carry: FF+01+0 -> sum=%h cout=%b", obs_sum, obs_cout);
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL carry1_sum got=%h exp=%h", obs_sum, e.sum); end
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL carry1_cout got=%b exp=%b", obs_cout, e.cout); end
        @(negedge clk);
        start_add(8'hFF, 8'hFF, 1'b1);
        wait_done("carry2", 0);
        e = sb.pop_front();
        $display("carry: FF+FF+1 -> sum=%h cout=%b", obs_sum, obs_cout);
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL carry2_sum got=%h exp=%h", obs_sum, e.sum); end
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL carry2_cout got=%b exp=%b", obs_cout, e.cout); end
        @(negedge clk);
    endtask

    task test_back_to_back;
        exp_t e;
        start_add(8'h55, 8'h22, 1'b0);
        wait_done("b2b_first", 0);
        e = sb.pop_front();
        $display("b2b: 55+22+0 -> sum=%h cout=%b", obs_sum, obs_cout);
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL b2b_first_sum got=%h exp=%h", obs_sum, e.sum); end
        // Still in the DONE cycle: this start must be accepted with no idle gap.
        start_add(8'h12, 8'h34, 1'b0);
        wait_done("b2b_second", 0);
        e = sb.pop_front();
        $display("b2b: 12+34+0 -> sum=%h cout=%b busy_cycles=%0d done_at=%0d", obs_sum, obs_cout, busy_cnt, done_idx);
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL b2b_busy_len got=%0d exp=8", busy_cnt); end
        checks++; if (done_idx !== 9) begin errors++; $display("FAIL b2b_latency got=%0d exp=9", done_idx); end
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL b2b_sum got=%h exp=%h", obs_sum, e.sum); end
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL b2b_cout got=%b exp=%b", obs_cout, e.cout); end
        @(negedge clk);
    endtask

    task test_start_ignored;
        exp_t e;
        start_add(8'h03, 8'h04, 1'b0);
        wait_done("ignore", 3);
        e = sb.pop_front();
        $display("ignore: 03+04+0 with stray start -> sum=%h cout=%b busy_cycles=%0d", obs_sum, obs_cout, busy_cnt);
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL ignore_busy_len got=%0d exp=8", busy_cnt); end
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL ignore_sum got=%h exp=%h", obs_sum, e.sum); end
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL ignore_cout got=%b exp=%b", obs_cout, e.cout); end
        @(negedge clk);
    endtask

    task test_async_reset;
        exp_t e;
        // Leave cout=1 from a prior add so the reset has something to clear.
        start_add(8'hFF, 8'h01, 1'b0);
        wait_done("pre_reset", 0);
        e = sb.pop_front();
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL pre_reset_cout got=%b exp=%b", obs_cout, e.cout); end
        @(negedge clk);
        start_add(8'h80, 8'h80, 1'b0);
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        $display("areset: mid-shift reset -> busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL areset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL areset_cout got=%b exp=0", cout); end
        sb.delete();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_hold_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_add(8'h01, 8'h02, 1'b0);
        wait_done("post_reset", 0);
        e = sb.pop_front();
        $display("areset: 01+02+0 after release -> sum=%h cout=%b", obs_sum, obs_cout);
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL post_reset_sum got=%h exp=%h", obs_sum, e.sum); end
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL post_reset_cout got=%b exp=%b", obs_cout, e.cout); end
        @(negedge clk);
    endtask

    task test_random;
        exp_t e;
        for (int n = 0; n < 6; n++) begin
            start_add(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_done("random", 0);
            e = sb.pop_front();
            $display("random[%0d]: %h+%h+%b -> sum=%h cout=%b", n, a_i, b_i, cin_i, obs_sum, obs_cout);
            checks++; if ({obs_cout, obs_sum} !== {e.cout, e.sum})
                begin errors++; $display("FAIL random_%0d got=%b_%h exp=%b_%h", n, obs_cout, obs_sum, e.cout, e.sum); end
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task test_ovf;
        exp_t e;
        start_add(8'h7F, 8'h01, 1'b0);
        wait_done("ovf1", 0);
        e = sb.pop_front();
        $display("ovf: 7F+01+0 -> sum=%h cout=%b ovf=%b", obs_sum, obs_cout, obs_ovf);
        checks++; if (obs_sum !== e.sum) begin errors++; $display("FAIL ovf1_sum got=%h exp=%h", obs_sum, e.sum); end
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL ovf1_cout got=%b exp=%b", obs_cout, e.cout); end
        checks++; if (obs_ovf !== e.ovf) begin errors++; $display("FAIL ovf1_ovf got=%b exp=%b", obs_ovf, e.ovf); end
        @(negedge clk);
        start_add(8'hFF, 8'h01, 1'b0);
        wait_done("ovf2", 0);
        e = sb.pop_front();
        $display("ovf: FF+01+0 -> sum=%h cout=%b ovf=%b", obs_sum, obs_cout, obs_ovf);
        checks++; if (obs_cout !== e.cout) begin errors++; $display("FAIL ovf2_cout got=%b exp=%b", obs_cout, e.cout); end
        checks++; if (obs_ovf !== e.ovf) begin errors++; $display("FAIL ovf2_ovf got=%b exp=%b", obs_ovf, e.ovf); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        cin_i = 1'b0;
        obs_ovf = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_start_ignored();
        test_async_reset();
        test_random();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
